// File: rtl/pos_sub_shifted_seq_pkg.sv
// Shared definitions for the sequential shifted subtractor: FSM encoding and
// elaboration-time sizing helpers, reusable by a future sequential adder.
package pos_sub_shifted_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int max_i(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    function automatic int ceil_div(input int x, input int y);
        return (x + y - 1) / y;
    endfunction

endpackage

// File: rtl/pos_sub_shifted_seq_if.sv
// Operand/result handshake bundle for pos_sub_shifted_seq; the result width
// follows the same W = max(N_BITS_L, N_BITS_R + SHIFT) rule as the datapath.
interface pos_sub_shifted_seq_if
    import pos_sub_shifted_seq_pkg::*;
#(
    parameter int N_BITS_L = 8,
    parameter int N_BITS_R = 8,
    parameter int SHIFT    = 0
);
    localparam int W = max_i(N_BITS_L, N_BITS_R + SHIFT);

    logic                in_valid;
    logic                in_ready;
    logic [N_BITS_L-1:0] a;
    logic [N_BITS_R-1:0] b;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        c;
    logic                neg;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, neg
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, neg
    );
endinterface

// File: rtl/pos_sub_chunk.sv
// Combinational CHUNK-bit slice of a rippled subtraction: d = x - y - bin,
// bout set when the slice needed to borrow from the next one up.
module pos_sub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);
    logic [CHUNK:0] diff_s;

    // Extra top bit of the widened difference is the borrow out.
    always_comb begin
        diff_s = {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bin};
        d      = diff_s[CHUNK-1:0];
        bout   = diff_s[CHUNK];
    end
endmodule

// File: rtl/pos_sub_shifted_seq.sv
// Multi-cycle c = a - (b << SHIFT), one CHUNK-bit slice per cycle with a
// rippled borrow; neg reports the borrow out of the top result bit.
module pos_sub_shifted_seq
    import pos_sub_shifted_seq_pkg::*;
#(
    parameter int N_BITS_L = 8,
    parameter int N_BITS_R = 8,
    parameter int SHIFT    = 0,
    parameter int CHUNK    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pos_sub_shifted_seq_if.slave bus
);
    localparam int W   = max_i(N_BITS_L, N_BITS_R + SHIFT);
    localparam int CW  = (CHUNK < W) ? CHUNK : W;
    localparam int NCH = ceil_div(W, CW);
    localparam int LW  = W - (NCH - 1) * CW;
    localparam int LWI = (LW < CW) ? LW : 0;
    localparam int IW  = $clog2(NCH + 1);

    state_e          state_q;
    logic [IW-1:0]   idx_q;
    logic            borrow_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    c_q;
    logic            neg_q;
    logic            in_ready_q;
    logic            out_valid_q;

    logic [W-1:0]    a_ext_s;
    logic [W-1:0]    b_ext_s;
    logic [CW-1:0]   x_s;
    logic [CW-1:0]   y_s;
    logic [CW-1:0]   d_s;
    logic            bout_s;
    logic            last_s;
    logic            last_borrow_s;
    logic [W-1:0]    c_d;

    // Zero-extend operands to W; shifted b leaves its low SHIFT bits clear.
    always_comb begin
        a_ext_s = W'(bus.a);
        b_ext_s = W'(bus.b) << SHIFT;
    end

    // Select the active slice of the captured operands.
    always_comb begin
        x_s = '0;
        y_s = '0;
        for (int i = 0; i < W; i++) begin
            if (i / CW == int'(idx_q)) begin
                x_s[i % CW] = a_q[i];
                y_s[i % CW] = b_q[i];
            end else begin
                x_s[i % CW] = x_s[i % CW];
            end
        end
    end

    pos_sub_chunk #(.CHUNK(CW)) u_chunk (
        .x    (x_s),
        .y    (y_s),
        .bin  (borrow_q),
        .d    (d_s),
        .bout (bout_s)
    );

    // Merge the slice result; a short last slice takes its borrow from bit LW,
    // since its zero padding makes every bit above LW a copy of the borrow.
    always_comb begin
        c_d    = c_q;
        last_s = (idx_q == IW'(NCH - 1));
        for (int i = 0; i < W; i++) begin
            if (i / CW == int'(idx_q)) begin
                c_d[i] = d_s[i % CW];
            end else begin
                c_d[i] = c_q[i];
            end
        end
        if (LW == CW) begin
            last_borrow_s = bout_s;
        end else begin
            last_borrow_s = d_s[LWI];
        end
    end

    // Control FSM with registered handshake outputs and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            borrow_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            neg_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= a_ext_s;
                        b_q        <= b_ext_s;
                        idx_q      <= '0;
                        borrow_q   <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    c_q      <= c_d;
                    borrow_q <= bout_s;
                    if (last_s) begin
                        neg_q       <= last_borrow_s;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.c         = c_q;
    assign bus.neg       = neg_q;

endmodule

// File: tb/tb_pos_sub_shifted_seq.sv
// Bench: default-config DUT with a vector table and directed corner sequences,
// plus eight parameter configurations swept against an arithmetic model.
module tb_pos_sub_shifted_seq;

    typedef struct {
        logic [31:0] c;
        logic        neg;
        int          acc;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic       neg;
    } vec_t;

    localparam int NG   = 8;
    localparam int NOPS = 40;
    localparam int G_NL [NG] = '{8, 4, 8, 8, 8, 8, 8, 8};
    localparam int G_NR [NG] = '{4, 4, 8, 8, 8, 8, 8, 8};
    localparam int G_SH [NG] = '{4, 2, 0, 0, 0, 3, 3, 3};
    localparam int G_CH [NG] = '{4, 2, 1, 3, 8, 1, 3, 8};
    localparam int G_DA0[NG] = '{243, 5, 0, 0, 0, 0, 0, 0};
    localparam int G_DB0[NG] = '{15, 1, 255, 255, 255, 255, 255, 255};
    localparam int G_DA1[NG] = '{16, 0, 255, 255, 255, 8, 8, 8};
    localparam int G_DB1[NG] = '{2, 15, 255, 255, 255, 1, 1, 1};

    logic clk = 1'b0;
    logic rst_a;
    logic rst_g;
    bit   start = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_done = 0;

    exp_t sb_a[$];
    vec_t tbl[8];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic mark_done();
        n_done++;
    endtask

    pos_sub_shifted_seq_if #(.N_BITS_L(8), .N_BITS_R(8), .SHIFT(0)) ifa ();

    pos_sub_shifted_seq #(.N_BITS_L(8), .N_BITS_R(8), .SHIFT(0), .CHUNK(4)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa.slave)
    );

    // Wait for in_ready, present one operand pair, push its expected result.
    task automatic a_issue(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ec, input logic en);
        int g;
        exp_t e;
        g = 0;
        while (!ifa.in_ready && g < 50) begin
            @(posedge clk); #1; g++;
        end
        chk(ifa.in_ready == 1'b1, "a_ready_wait", 32'(ifa.in_ready), 32'd1);
        ifa.in_valid = 1'b1;
        ifa.a = av;
        ifa.b = bv;
        e.c = 32'(ec);
        e.neg = en;
        e.acc = 0;
        sb_a.push_back(e);
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
    endtask

    // Wait for out_valid (latency counted from the accept cycle), compare, hand off.
    task automatic a_collect(input string name);
        int lat;
        exp_t e;
        lat = 1;
        while (!ifa.out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        chk(lat == 3, {name, "_latency"}, 32'(lat), 32'd3);
        if (sb_a.size() == 0) begin
            chk(1'b0, {name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_a.pop_front();
            chk(32'(ifa.c) == e.c, {name, "_c"}, 32'(ifa.c), e.c);
            chk(ifa.neg == e.neg, {name, "_neg"}, 32'(ifa.neg), 32'(e.neg));
        end
        ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        ifa.out_ready = 1'b0;
        chk(ifa.in_ready == 1'b1 && ifa.out_valid == 1'b0, {name, "_handoff"},
            {30'd0, ifa.in_ready, ifa.out_valid}, 32'd2);
    endtask

    initial begin
        int g;
        rst_a = 1'b1;
        rst_g = 1'b1;
        ifa.in_valid = 1'b0;
        ifa.a = 8'd0;
        ifa.b = 8'd0;
        ifa.out_ready = 1'b0;
        tbl[0] = '{8'd200, 8'd55,  8'd145, 1'b0};
        tbl[1] = '{8'd55,  8'd200, 8'd111, 1'b1};
        tbl[2] = '{8'd9,   8'd9,   8'd0,   1'b0};
        tbl[3] = '{8'd0,   8'd255, 8'd1,   1'b1};
        tbl[4] = '{8'd255, 8'd0,   8'd255, 1'b0};
        tbl[5] = '{8'd255, 8'd255, 8'd0,   1'b0};
        tbl[6] = '{8'd128, 8'd129, 8'd255, 1'b1};
        tbl[7] = '{8'd16,  8'd1,   8'd15,  1'b0};

        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_g = 1'b0;
        chk(ifa.in_ready == 1'b1, "rst_in_ready", 32'(ifa.in_ready), 32'd1);
        chk(ifa.out_valid == 1'b0, "rst_out_valid", 32'(ifa.out_valid), 32'd0);
        chk(ifa.c == 8'd0, "rst_c", 32'(ifa.c), 32'd0);
        chk(ifa.neg == 1'b0, "rst_neg", 32'(ifa.neg), 32'd0);
        start = 1'b1;

        for (int i = 0; i < 8; i++) begin
            a_issue(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].neg);
            a_collect($sformatf("vec%0d", i));
        end

        // Backpressure: result held, new operands ignored while DONE.
        a_issue(8'd200, 8'd55, 8'd145, 1'b0);
        g = 1;
        while (!ifa.out_valid && g < 50) begin
            @(posedge clk); #1; g++;
        end
        for (int i = 0; i < 10; i++) begin
            ifa.in_valid = 1'b1;
            ifa.a = 8'($urandom);
            ifa.b = 8'($urandom);
            @(posedge clk); #1;
            chk(ifa.out_valid == 1'b1 && ifa.in_ready == 1'b0, "bp_hs",
                {30'd0, ifa.out_valid, ifa.in_ready}, 32'd2);
            chk(ifa.c == 8'd145 && ifa.neg == 1'b0, "bp_c", 32'({ifa.neg, ifa.c}), 32'd145);
        end
        ifa.in_valid = 1'b0;
        sb_a.delete();
        ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        ifa.out_ready = 1'b0;
        chk(ifa.in_ready == 1'b1 && ifa.out_valid == 1'b0, "bp_release",
            {30'd0, ifa.in_ready, ifa.out_valid}, 32'd2);
        @(posedge clk); #1;
        chk(ifa.c == 8'd145 && ifa.in_ready == 1'b1, "idle_hold_c", 32'(ifa.c), 32'd145);

        // Reset in the first RUN cycle discards the partial result.
        ifa.in_valid = 1'b1;
        ifa.a = 8'd3;
        ifa.b = 8'd250;
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        chk(ifa.in_ready == 1'b1, "midrst_in_ready", 32'(ifa.in_ready), 32'd1);
        chk(ifa.out_valid == 1'b0, "midrst_out_valid", 32'(ifa.out_valid), 32'd0);
        chk(ifa.c == 8'd0 && ifa.neg == 1'b0, "midrst_c", 32'({ifa.neg, ifa.c}), 32'd0);
        a_issue(8'd9, 8'd9, 8'd0, 1'b0);
        a_collect("post_rst");

        g = 0;
        while (n_done < NG && g < 40000) begin
            @(posedge clk); g++;
        end
        chk(n_done == NG, "sweep_complete", 32'(n_done), 32'(NG));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    for (genvar gi = 0; gi < NG; gi++) begin : g_cfg
        localparam int NL  = G_NL[gi];
        localparam int NR  = G_NR[gi];
        localparam int SH  = G_SH[gi];
        localparam int CH  = G_CH[gi];
        localparam int W   = (NL > NR + SH) ? NL : NR + SH;
        localparam int NCH = (W + CH - 1) / CH;

        exp_t sbq[$];

        pos_sub_shifted_seq_if #(.N_BITS_L(NL), .N_BITS_R(NR), .SHIFT(SH)) bus ();

        pos_sub_shifted_seq #(.N_BITS_L(NL), .N_BITS_R(NR), .SHIFT(SH), .CHUNK(CH)) dut (
            .clk (clk),
            .rst (rst_g),
            .bus (bus.slave)
        );

        // Driver: garbage operands while busy, real ones once in_ready is seen.
        initial begin : drv
            logic [NL-1:0] av;
            logic [NR-1:0] bv;
            logic [31:0]   full;
            exp_t          e;
            int            guard;
            bus.in_valid = 1'b0;
            bus.a = '0;
            bus.b = '0;
            wait (start);
            @(posedge clk); #1;
            for (int i = 0; i < NOPS; i++) begin
                if (i == 0) begin
                    av = NL'(G_DA0[gi]);
                    bv = NR'(G_DB0[gi]);
                end else if (i == 1) begin
                    av = NL'(G_DA1[gi]);
                    bv = NR'(G_DB1[gi]);
                end else begin
                    av = NL'($urandom);
                    bv = NR'($urandom);
                end
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                guard = 0;
                while (!bus.in_ready && guard < 200) begin
                    bus.in_valid = 1'b1;
                    bus.a = NL'($urandom);
                    bus.b = NR'($urandom);
                    @(posedge clk); #1; guard++;
                end
                bus.in_valid = 1'b1;
                bus.a = av;
                bus.b = bv;
                full  = 32'(av) - (32'(bv) << SH);
                e.c   = full & ((32'd1 << W) - 32'd1);
                e.neg = (32'(bv) << SH) > 32'(av);
                @(posedge clk); #1;
                e.acc = cyc;
                sbq.push_back(e);
                bus.in_valid = 1'b0;
            end
        end

        // Monitor: random out_ready, latency and result checks against the queue.
        initial begin : mon
            int   got;
            int   guard;
            logic pv;
            exp_t e;
            got = 0;
            guard = 0;
            pv = 1'b0;
            bus.out_ready = 1'b0;
            wait (start);
            @(posedge clk); #1;
            while (got < NOPS && guard < 20000) begin
                if (bus.out_valid && !pv && sbq.size() > 0)
                    chk(cyc - sbq[0].acc == NCH, $sformatf("g%0d_latency", gi),
                        32'(cyc - sbq[0].acc), 32'(NCH));
                pv = bus.out_valid;
                bus.out_ready = ($urandom_range(0, 3) != 0);
                if (bus.out_valid && bus.out_ready) begin
                    if (sbq.size() == 0) begin
                        chk(1'b0, $sformatf("g%0d_sb_empty", gi), 32'd0, 32'd1);
                    end else begin
                        e = sbq.pop_front();
                        chk(32'(bus.c) == e.c, $sformatf("g%0d_op%0d_c", gi, got), 32'(bus.c), e.c);
                        chk(bus.neg == e.neg, $sformatf("g%0d_op%0d_neg", gi, got),
                            32'(bus.neg), 32'(e.neg));
                    end
                    got++;
                end
                @(posedge clk); #1; guard++;
            end
            bus.out_ready = 1'b0;
            if (got < NOPS) chk(1'b0, $sformatf("g%0d_timeout", gi), 32'(got), 32'(NOPS));
            mark_done();
        end
    end

endmodule
